// File: rtl/clkdiv_prog.sv
// clkdiv_prog: runtime-programmable divided clock / step-pulse generator with
// glitch-free period-boundary reprogramming and optional finite bursts.
module clkdiv_prog #(
    parameter int WIDTH    = 32,
    parameter int CNTW     = 16,
    parameter int DEF_DIV  = 50000000,
    parameter int DEF_HIGH = 25000000,
    parameter bit AUTORUN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] high_in,
    input  logic [CNTW-1:0]  pulses_in,
    output logic             clk_out,
    output logic             tick,
    output logic             done,
    output logic             busy
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state;
    logic [WIDTH-1:0] cnt, cnt_nxt, div_act, high_act, div_sh, high_sh, div_s, high_s;
    logic [CNTW-1:0] remaining;
    logic stop_pend, wrap, last;
    always_comb begin
        div_s   = (div_in < WIDTH'(2)) ? WIDTH'(2) : div_in;
        high_s  = (high_in > div_s) ? div_s : high_in;
        cnt_nxt = cnt + WIDTH'(1);
        wrap    = (cnt == div_act - WIDTH'(1));
        last    = (remaining == CNTW'(1)) || stop_pend || stop;
    end
    // done is raised on the final cycle of the final period and doubles as the
    // "leave RUN at this wrap" flag, so tick/done/state change stay aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= AUTORUN ? RUN : IDLE;
            cnt       <= '0;
            div_act   <= WIDTH'(DEF_DIV);
            div_sh    <= WIDTH'(DEF_DIV);
            high_act  <= WIDTH'(DEF_HIGH);
            high_sh   <= WIDTH'(DEF_HIGH);
            remaining <= '0;
            stop_pend <= 1'b0;
            tick      <= 1'b0;
            done      <= 1'b0;
            clk_out   <= AUTORUN && (DEF_HIGH > 0);
            busy      <= AUTORUN;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            if (state == IDLE) begin
                if (load) begin
                    div_sh   <= div_s;
                    div_act  <= div_s;
                    high_sh  <= high_s;
                    high_act <= high_s;
                end
                if (start) begin
                    state     <= RUN;
                    busy      <= 1'b1;
                    cnt       <= '0;
                    remaining <= pulses_in;
                    clk_out   <= (load ? high_s : high_act) != '0;
                end
            end else begin
                if (load) begin
                    div_sh  <= div_s;
                    high_sh <= high_s;
                end
                if (wrap) begin
                    cnt      <= '0;
                    div_act  <= div_sh;
                    high_act <= high_sh;
                    if (done) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        clk_out   <= 1'b0;
                        remaining <= '0;
                        stop_pend <= 1'b0;
                    end else begin
                        clk_out   <= high_sh != '0;
                        remaining <= remaining - CNTW'(remaining != '0);
                        stop_pend <= stop_pend | stop;
                    end
                end else begin
                    cnt       <= cnt_nxt;
                    clk_out   <= cnt_nxt < high_act;
                    stop_pend <= stop_pend | stop;
                    if (cnt_nxt == div_act - WIDTH'(1)) begin
                        tick <= 1'b1;
                        done <= last;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_clkdiv_prog.sv
// tb_clkdiv_prog: directed and random stimulus against a period-position
// reference model of the programmable divider.
module tb_clkdiv_prog;
    localparam int W = 32;
    localparam int C = 16;
    logic clk = 0, rst_n = 0, start = 0, stop = 0, load = 0;
    logic [W-1:0] div_in = 0, high_in = 0;
    logic [C-1:0] pulses_in = 0;
    logic clk_out, tick, done, busy;

    clkdiv_prog #(.WIDTH(W), .CNTW(C), .DEF_DIV(10), .DEF_HIGH(5), .AUTORUN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .load(load),
        .div_in(div_in), .high_in(high_in), .pulses_in(pulses_in),
        .clk_out(clk_out), .tick(tick), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int n_tick = 0, n_done = 0, n_high = 0;
    // model: position within the current period, active/shadow settings,
    // periods left (0 = endless) and whether a stop has been requested
    bit m_run;
    int m_pos, m_div, m_high, m_dsh, m_hsh, m_left;
    bit m_stop;
    bit e_clk, e_tick, e_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void expect_outs();
        e_tick = m_run && (m_pos == m_div - 1);
        e_done = e_tick && ((m_left == 1) || m_stop);
        e_clk  = m_run && (m_pos < m_high);
    endfunction

    task automatic model_edge();
        int ds, hs;
        ds = (int'(div_in) < 2) ? 2 : int'(div_in);
        hs = (int'(high_in) > ds) ? ds : int'(high_in);
        expect_outs();
        if (!rst_n) begin
            m_run = 1; m_pos = 0; m_div = 10; m_high = 5; m_dsh = 10; m_hsh = 5;
            m_left = 0; m_stop = 0;
        end else if (!m_run) begin
            if (load) begin
                m_div = ds; m_high = hs; m_dsh = ds; m_hsh = hs;
            end
            if (start) begin
                m_run = 1; m_pos = 0; m_left = int'(pulses_in);
            end
        end else begin
            if (e_tick) begin
                m_div = m_dsh; m_high = m_hsh; m_pos = 0;
                if (e_done) begin
                    m_run = 0; m_stop = 0; m_left = 0;
                end else begin
                    if (m_left > 0) m_left--;
                    m_stop = m_stop || stop;
                end
            end else begin
                m_pos++;
                m_stop = m_stop || stop;
            end
            if (load) begin
                m_dsh = ds; m_hsh = hs;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        expect_outs();
        check("clk_out", clk_out, e_clk);
        check("tick", tick, e_tick);
        check("done", done, e_done);
        check("busy", busy, m_run);
        n_tick += tick;
        n_done += done;
        n_high += clk_out;
    endtask

    task automatic pulse(input bit st, input bit sp, input bit ld, input int d, input int h, input int p);
        start = st; stop = sp; load = ld;
        div_in = W'(d); high_in = W'(h); pulses_in = C'(p);
        step();
        start = 0; stop = 0; load = 0;
    endtask

    task automatic clr();
        n_tick = 0; n_done = 0; n_high = 0;
    endtask

    task automatic wait_pos(input int p);
        int k;
        k = 0;
        while (!(m_run && m_pos == p) && k < 60) begin
            step();
            k++;
        end
        if (k >= 60) check("wait_timeout", 1, 0);
    endtask

    task automatic go_idle();
        int k;
        pulse(0, 1, 0, 0, 0, 0);
        k = 0;
        while (m_run && k < 60) begin
            step();
            k++;
        end
        check("idle_reached", busy, 0);
    endtask

    initial begin
        @(negedge clk);
        rst_n = 0;
        step(); step();
        check("rst_busy", busy, 1);
        check("rst_clk", clk_out, 1);
        rst_n = 1;
        clr();
        repeat (30) step();
        check("auto_ticks", n_tick, 3);
        check("auto_high", n_high, 15);

        wait_pos(3);
        clr();
        pulse(0, 1, 0, 0, 0, 0);
        repeat (5) step();
        check("stop_still_busy", busy, 1);
        repeat (4) step();
        check("stop_done_once", n_done, 1);
        check("stop_clk_low", clk_out, 0);

        clr();
        pulse(1, 0, 1, 4, 1, 3);
        repeat (16) step();
        check("burst3_ticks", n_tick, 3);
        check("burst3_highs", n_high, 3);
        check("burst3_done", n_done, 1);
        check("burst3_busy", busy, 0);

        pulse(1, 0, 1, 8, 4, 0);
        wait_pos(2);
        pulse(0, 0, 1, 6, 3, 0);
        clr();
        repeat (29) step();
        check("reprog_ticks", n_tick, 5);
        go_idle();

        clr();
        pulse(1, 0, 1, 0, 9, 0);
        repeat (7) step();
        check("const_high", n_high, 8);
        check("div2_ticks", n_tick, 4);
        pulse(0, 0, 1, 0, 0, 0);
        repeat (3) step();
        clr();
        repeat (8) step();
        check("const_low", n_high, 0);
        check("low_ticks", n_tick, 4);
        go_idle();

        pulse(1, 0, 1, 4, 2, 5);
        begin
            int k;
            k = 0;
            while (!(m_left == 3 && m_pos == 1) && k < 60) begin
                step();
                k++;
            end
            if (k >= 60) check("burst5_timeout", 1, 0);
        end
        clr();
        rst_n = 0;
        step();
        rst_n = 1;
        check("rst_mid_done", n_done, 0);
        check("rst_mid_busy", busy, 1);
        repeat (3) step();

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            start = ($urandom_range(0, 5) == 0);
            stop = ($urandom_range(0, 19) == 0);
            load = ($urandom_range(0, 7) == 0);
            div_in = W'($urandom_range(0, 12));
            high_in = W'($urandom_range(0, 14));
            pulses_in = C'($urandom_range(0, 4));
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
